// File: rtl/div_seq_ctrl.sv
// Sequencing controller for a 32-step radix-2 restoring divider (DIV/DIVU).
// Latches operands on start, iterates one quotient bit per cycle, returns {rem, quo}.
module div_seq_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_opdata1,
    input  logic [31:0] div_opdata2,
    input  logic        div_annul,
    output logic [63:0] div_result,
    output logic        div_ready,
    output logic        stallreq_for_div
);

    localparam int CNT_W = $clog2(DIV_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [63:0]      result_q, result_d;
    logic             ready_q, ready_d;

    logic [32:0]      rem_sh;
    logic [31:0]      rem_sub;
    logic             ge;
    logic [31:0]      rem_step;
    logic [31:0]      quo_step;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    always_comb begin
        // 33-bit partial remainder; low 32 bits of the difference are exact whenever ge holds
        rem_sh   = {rem_q, quo_q[31]};
        ge       = (rem_sh >= {1'b0, dvs_q});
        rem_sub  = rem_sh[31:0] - dvs_q;
        rem_step = ge ? rem_sub : rem_sh[31:0];
        quo_step = {quo_q[30:0], ge};

        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = 64'b0;
                if (div_start && !div_annul) begin
                    if (div_opdata2 == 32'b0) begin
                        state_d = BY_ZERO;
                    end else begin
                        quo_d   = cond_neg(div_opdata1, div_opdata1[31] & div_signed);
                        dvs_d   = cond_neg(div_opdata2, div_opdata2[31] & div_signed);
                        rem_d   = 32'b0;
                        qneg_d  = (div_opdata1[31] ^ div_opdata2[31]) & div_signed;
                        rneg_d  = div_opdata1[31] & div_signed;
                        cnt_d   = '0;
                        state_d = ON;
                    end
                end
            end
            BY_ZERO: begin
                result_d = 64'b0;
                ready_d  = 1'b1;
                state_d  = END;
            end
            ON: begin
                if (div_annul) begin
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = FREE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        result_d = {cond_neg(rem_step, rneg_q), cond_neg(quo_step, qneg_q)};
                        ready_d  = 1'b1;
                        cnt_d    = '0;
                        state_d  = END;
                    end
                end
            end
            END: begin
                // Result is held only while EX keeps the divide; dropping start discards it
                if (!div_start || div_annul) begin
                    ready_d  = 1'b0;
                    result_d = 64'b0;
                    state_d  = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            rem_q    <= 32'b0;
            quo_q    <= 32'b0;
            dvs_q    <= 32'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 64'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign div_result       = result_q;
    assign div_ready        = ready_q;
    assign stallreq_for_div = div_start & ~ready_q & ~div_annul;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: driver queues expected {rem, quo} and ready cycle,
// a negedge monitor pops and compares each time div_ready rises.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stallreq_for_div;

    div_seq_ctrl #(.DIV_CYCLES(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .div_start        (div_start),
        .div_signed       (div_signed),
        .div_opdata1      (div_opdata1),
        .div_opdata2      (div_opdata2),
        .div_annul        (div_annul),
        .div_result       (div_result),
        .div_ready        (div_ready),
        .stallreq_for_div (stallreq_for_div)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] res;
        int          at_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rdy_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every rising div_ready must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (div_ready && !rdy_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual=%h required=none (t=%0t)", div_result, $time);
            end else begin
                e = exp_q.pop_front();
                chk("result", div_result, e.res);
                chk("ready_cycle", 64'(cyc), 64'(e.at_cyc));
            end
        end
        rdy_prev = div_ready;
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] res, input int lat, input string name);
        exp_t e;
        int   n;
        bit   done;
        @(negedge clk);
        div_start   = 1'b1;
        div_signed  = s;
        div_opdata1 = a;
        div_opdata2 = b;
        e.res    = res;
        e.at_cyc = cyc + lat;
        exp_q.push_back(e);
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (stallreq_for_div) n++;
            @(negedge clk);
            if (div_ready) begin
                done = 1'b1;
                break;
            end
            // Operands must be ignored once the FSM has left FREE
            div_opdata1 = $urandom;
            div_opdata2 = $urandom;
            div_signed  = 1'($urandom);
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_stall_cycles"}, 64'(n), 64'(lat));
        @(negedge clk);
        #1;
        chk({name, "_hold_ready"}, 64'(div_ready), 64'd1);
        chk({name, "_hold_result"}, div_result, res);
        chk({name, "_stall_end"}, 64'(stallreq_for_div), 64'd0);
        div_start = 1'b0;
        @(negedge clk);
        chk({name, "_drop_ready"}, 64'(div_ready), 64'd0);
        chk({name, "_drop_result"}, div_result, 64'd0);
    endtask

    task automatic idle_check(input int ncyc, input string name);
        int seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (div_ready) seen++;
        end
        chk({name, "_no_ready"}, 64'(seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        rst         = 1'b1;
        div_start   = 1'b0;
        div_signed  = 1'b0;
        div_opdata1 = 32'b0;
        div_opdata2 = 32'b0;
        div_annul   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 64'(div_ready), 64'd0);
        chk("reset_result", div_result, 64'd0);
        chk("reset_stall", 64'(stallreq_for_div), 64'd0);
        rst = 1'b0;

        run_op(32'd100,       32'd7,         1'b0, {32'd2, 32'd14},                  33, "divu_100_7");
        run_op(32'hFFFFFFF9,  32'h00000002,  1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD},     33, "div_m7_2");
        run_op(32'h00000007,  32'hFFFFFFFE,  1'b1, {32'h00000001, 32'hFFFFFFFD},     33, "div_7_m2");
        run_op(32'h80000000,  32'hFFFFFFFF,  1'b1, {32'h0, 32'h80000000},            33, "div_min_m1");
        run_op(32'hFFFFFFFF,  32'h00000001,  1'b0, {32'h0, 32'hFFFFFFFF},            33, "divu_max_1");
        run_op(32'h80000000,  32'hFFFFFFFF,  1'b0, {32'h80000000, 32'h0},            33, "divu_big");
        run_op(32'h12345678,  32'h0,         1'b0, 64'd0,                            2,  "divu_by0");
        run_op(32'h80000000,  32'h0,         1'b1, 64'd0,                            2,  "div_by0");

        // Annul pulsed mid-ON: operation discarded, no ready
        @(negedge clk);
        div_start   = 1'b1;
        div_signed  = 1'b0;
        div_opdata1 = 32'd100;
        div_opdata2 = 32'd7;
        repeat (10) @(negedge clk);
        div_annul = 1'b1;
        #1;
        chk("annul_stall_masked", 64'(stallreq_for_div), 64'd0);
        @(negedge clk);
        div_annul = 1'b0;
        div_start = 1'b0;
        #1;
        chk("annul_stall_after", 64'(stallreq_for_div), 64'd0);
        idle_check(40, "annul");
        run_op(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, "after_annul");

        // Start and annul together in FREE: annul wins
        @(negedge clk);
        div_start   = 1'b1;
        div_annul   = 1'b1;
        div_opdata1 = 32'd9;
        div_opdata2 = 32'd3;
        idle_check(3, "start_annul");
        div_start = 1'b0;
        div_annul = 1'b0;
        idle_check(40, "start_annul_after");

        // Async reset while END holds a result
        begin
            exp_t e;
            @(negedge clk);
            div_start   = 1'b1;
            div_signed  = 1'b0;
            div_opdata1 = 32'd15;
            div_opdata2 = 32'd4;
            e.res    = {32'd3, 32'd3};
            e.at_cyc = cyc + 33;
            exp_q.push_back(e);
            got = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (div_ready) begin
                    got = 1;
                    break;
                end
            end
            chk("end_rst_reached", 64'(got), 64'd1);
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("end_rst_ready", 64'(div_ready), 64'd0);
            chk("end_rst_result", div_result, 64'd0);
            div_start = 1'b0;
            @(negedge clk);
            rst = 1'b0;
        end

        // Async reset mid-ON, then a fresh divide with full latency
        @(negedge clk);
        div_start   = 1'b1;
        div_signed  = 1'b0;
        div_opdata1 = 32'd100;
        div_opdata2 = 32'd7;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("on_rst_ready", 64'(div_ready), 64'd0);
        chk("on_rst_result", div_result, 64'd0);
        div_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle_check(40, "on_rst");
        run_op(32'd15, 32'd4, 1'b0, {32'd3, 32'd3}, 33, "after_rst");

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
